// File: rtl/writeback_unit_pkg.sv
// Shared constants and the result-queue entry layout for the writeback unit.
package writeback_unit_pkg;

   localparam int unsigned WORDSIZE    = 64;
   localparam int unsigned REGADDRSIZE = 5;
   localparam int unsigned NUMREGS     = 2 ** REGADDRSIZE;
   localparam logic [REGADDRSIZE-1:0] XZR = REGADDRSIZE'(31);

   localparam int unsigned WB_DEPTH = 4;
   localparam int unsigned WB_CNTW  = 2;

   typedef struct packed {
      logic [REGADDRSIZE-1:0] rd;
      logic [WORDSIZE-1:0]    data;
   } wb_entry_t;

endpackage

// File: rtl/writeback_unit_fifo.sv
// Result queue: DEPTH-entry sync FIFO with two ordered push ports and one pop port.
module wb_fifo
   import writeback_unit_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push0,
   input  wb_entry_t                din0,
   input  logic                     push1,
   input  wb_entry_t                din1,
   input  logic                     pop,
   output wb_entry_t                head,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   occupancy
);

   localparam int unsigned PTRW = $clog2(DEPTH);
   localparam int unsigned OCCW = PTRW + 1;

   wb_entry_t        mem [DEPTH];
   logic [PTRW-1:0]  wptr;
   logic [PTRW-1:0]  rptr;
   logic [PTRW-1:0]  wptr1;
   logic [OCCW-1:0]  occ;
   logic             do_pop;

   assign empty     = (occ == '0);
   assign occupancy = occ;
   assign do_pop    = pop && !empty;
   // The second port lands just behind the first when both push.
   assign wptr1     = wptr + PTRW'(push0);
   assign head      = empty ? '0 : mem[rptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
         occ  <= '0;
      end else begin
         wptr <= wptr + PTRW'(push0) + PTRW'(push1);
         if (do_pop) rptr <= rptr + PTRW'(1);
         occ  <= occ + OCCW'(push0) + OCCW'(push1) - OCCW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push0) mem[wptr]  <= din0;
      if (push1) mem[wptr1] <= din1;
   end

endmodule

// File: rtl/writeback_unit.sv
// Register-file write master: queues ALU/load results, drains one write per cycle,
// and tracks pending writes per register for decode hazard checks.
module writeback_unit
   import writeback_unit_pkg::*;
#(
   parameter int unsigned DEPTH = WB_DEPTH,
   parameter int unsigned CNTW  = WB_CNTW
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   claim,
   input  logic [REGADDRSIZE-1:0] claim_rd,
   output logic                   claim_ok,
   input  logic [REGADDRSIZE-1:0] qn,
   input  logic [REGADDRSIZE-1:0] qm,
   output logic                   busy_n,
   output logic                   busy_m,
   input  logic                   alu_valid,
   input  logic [REGADDRSIZE-1:0] alu_rd,
   input  logic [WORDSIZE-1:0]    alu_data,
   output logic                   alu_ready,
   input  logic                   ld_valid,
   input  logic [REGADDRSIZE-1:0] ld_rd,
   input  logic [WORDSIZE-1:0]    ld_data,
   output logic                   ld_ready,
   output logic [REGADDRSIZE-1:0] rf_rd,
   output logic [WORDSIZE-1:0]    rf_in,
   output logic                   rf_wren
);

   localparam int unsigned OCCW = $clog2(DEPTH) + 1;
   localparam logic [CNTW-1:0] CNT_MAX = '1;

   logic [OCCW-1:0]    occupancy;
   logic [OCCW-1:0]    free;
   logic               fifo_empty;
   wb_entry_t          head;
   wb_entry_t          ld_entry;
   wb_entry_t          alu_entry;
   logic               ld_push;
   logic               alu_push;
   logic               pop;
   logic               claim_inc;
   logic               pop_dec;
   logic [NUMREGS-1:0] inc_vec;
   logic [NUMREGS-1:0] dec_vec;
   logic [CNTW-1:0]    count [NUMREGS];

   // Load has priority for the last free slot; readiness never looks at alu_valid.
   assign free      = OCCW'(DEPTH) - occupancy;
   assign ld_ready  = (free >= OCCW'(1));
   assign alu_ready = (free >= (OCCW'(1) + OCCW'(ld_valid)));

   assign ld_push   = ld_valid  && ld_ready  && (ld_rd  != XZR);
   assign alu_push  = alu_valid && alu_ready && (alu_rd != XZR);
   assign ld_entry  = '{rd: ld_rd,  data: ld_data};
   assign alu_entry = '{rd: alu_rd, data: alu_data};

   wb_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push0     (ld_push),
      .din0      (ld_entry),
      .push1     (alu_push),
      .din1      (alu_entry),
      .pop       (pop),
      .head      (head),
      .empty     (fifo_empty),
      .occupancy (occupancy)
   );

   assign pop     = !fifo_empty;
   assign rf_wren = pop;
   assign rf_rd   = head.rd;
   assign rf_in   = head.data;

   assign claim_ok  = (claim_rd == XZR) || (count[claim_rd] != CNT_MAX);
   assign claim_inc = claim && claim_ok && (claim_rd != XZR);
   // A pop against an already-zero counter leaves it at zero.
   assign pop_dec   = pop && (count[head.rd] != '0);
   assign busy_n    = (qn != XZR) && (count[qn] != '0);
   assign busy_m    = (qm != XZR) && (count[qm] != '0);

   always_comb begin
      inc_vec = '0;
      dec_vec = '0;
      if (claim_inc) inc_vec[claim_rd] = 1'b1;
      if (pop_dec)   dec_vec[head.rd]  = 1'b1;
   end

   always_ff @(posedge clk) begin
      for (int r = 0; r < int'(NUMREGS); r++) begin
         if (reset)                       count[r] <= '0;
         else if (inc_vec[r] && !dec_vec[r]) count[r] <= count[r] + CNTW'(1);
         else if (dec_vec[r] && !inc_vec[r]) count[r] <= count[r] - CNTW'(1);
      end
   end

   // Producer wrote a register nobody reserved.
   always_ff @(posedge clk) begin
      if (!reset && pop) begin
         assert (count[head.rd] != '0)
            else $error("writeback_unit: write to unreserved register %0d", head.rd);
      end
   end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit with a queue/array reference model and pinned literal expectations.
module tb_writeback_unit;
   import writeback_unit_pkg::*;

   localparam int MDEPTH = 4;
   localparam int MAXCNT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        claim;
   logic [4:0]  claim_rd;
   logic        claim_ok;
   logic [4:0]  qn, qm;
   logic        busy_n, busy_m;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [63:0] alu_data;
   logic        alu_ready;
   logic        ld_valid;
   logic [4:0]  ld_rd;
   logic [63:0] ld_data;
   logic        ld_ready;
   logic [4:0]  rf_rd;
   logic [63:0] rf_in;
   logic        rf_wren;

   writeback_unit dut (
      .clk(clk), .reset(reset),
      .claim(claim), .claim_rd(claim_rd), .claim_ok(claim_ok),
      .qn(qn), .qm(qm), .busy_n(busy_n), .busy_m(busy_m),
      .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
      .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
      .rf_rd(rf_rd), .rf_in(rf_in), .rf_wren(rf_wren)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [4:0]  rd;
      logic [63:0] data;
   } ment_t;

   ment_t mq[$];
   int    mcnt[32];
   bit    model_ok = 1'b0;

   // Pinned literal expectations for the current cycle
   bit p_rf_en, p_bn_en, p_cok_en, p_ar_en, p_lr_en;
   bit p_wren, p_bn, p_cok, p_ar, p_lr;
   int p_rd;
   logic [63:0] p_data;

   // Reference model: queue of accepted results and per-register pending counts
   always @(posedge clk) begin : model_upd
      int    free;
      bit    ldr, alur, cok;
      ment_t e;
      if (reset) begin
         mq.delete();
         foreach (mcnt[i]) mcnt[i] = 0;
         model_ok = 1'b1;
      end else if (model_ok) begin
         free = MDEPTH - mq.size();
         ldr  = (free >= 1);
         alur = (free >= 1 + int'(ld_valid));
         cok  = (claim_rd == 5'd31) || (mcnt[claim_rd] < MAXCNT);
         if (mq.size() > 0) begin
            e = mq.pop_front();
            if (mcnt[e.rd] > 0) mcnt[e.rd] = mcnt[e.rd] - 1;
         end
         if (claim && cok && claim_rd != 5'd31) mcnt[claim_rd] = mcnt[claim_rd] + 1;
         if (ld_valid && ldr && ld_rd != 5'd31)    mq.push_back('{ld_rd, ld_data});
         if (alu_valid && alur && alu_rd != 5'd31) mq.push_back('{alu_rd, alu_data});
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks = checks + 1;
      if (act !== exp) begin
         failures = failures + 1;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin : compare
      int free;
      if (model_ok && !reset) begin
         free = MDEPTH - mq.size();
         chk("ld_ready",  64'(ld_ready),  64'(free >= 1));
         chk("alu_ready", 64'(alu_ready), 64'(free >= 1 + int'(ld_valid)));
         chk("rf_wren",   64'(rf_wren),   64'(mq.size() != 0));
         chk("rf_rd",     64'(rf_rd),     (mq.size() != 0) ? 64'(mq[0].rd) : 64'd0);
         chk("rf_in",     rf_in,          (mq.size() != 0) ? mq[0].data : 64'd0);
         chk("busy_n",    64'(busy_n),    64'((qn != 5'd31) && (mcnt[qn] != 0)));
         chk("busy_m",    64'(busy_m),    64'((qm != 5'd31) && (mcnt[qm] != 0)));
         chk("claim_ok",  64'(claim_ok),  64'((claim_rd == 5'd31) || (mcnt[claim_rd] < MAXCNT)));
         if (p_rf_en) begin
            chk("pin_rf_wren", 64'(rf_wren), 64'(p_wren));
            chk("pin_rf_rd",   64'(rf_rd),   64'(p_rd));
            chk("pin_rf_in",   rf_in,        p_data);
         end
         if (p_bn_en)  chk("pin_busy_n",    64'(busy_n),    64'(p_bn));
         if (p_cok_en) chk("pin_claim_ok",  64'(claim_ok),  64'(p_cok));
         if (p_ar_en)  chk("pin_alu_ready", 64'(alu_ready), 64'(p_ar));
         if (p_lr_en)  chk("pin_ld_ready",  64'(ld_ready),  64'(p_lr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      p_rf_en = 0; p_bn_en = 0; p_cok_en = 0; p_ar_en = 0; p_lr_en = 0;
   endtask

   task automatic idle();
      claim = 0; alu_valid = 0; ld_valid = 0;
   endtask

   task automatic pin_rf(input bit w, input int rd, input logic [63:0] d);
      p_rf_en = 1; p_wren = w; p_rd = rd; p_data = d;
   endtask
   task automatic pin_bn(input bit v);  p_bn_en = 1;  p_bn = v;  endtask
   task automatic pin_cok(input bit v); p_cok_en = 1; p_cok = v; endtask
   task automatic pin_ar(input bit v);  p_ar_en = 1;  p_ar = v;  endtask
   task automatic pin_lr(input bit v);  p_lr_en = 1;  p_lr = v;  endtask

   task automatic alu(input int rd, input logic [63:0] d);
      alu_valid = 1; alu_rd = 5'(rd); alu_data = d;
   endtask
   task automatic ld(input int rd, input logic [63:0] d);
      ld_valid = 1; ld_rd = 5'(rd); ld_data = d;
   endtask
   task automatic do_claim(input int rd);
      claim = 1; claim_rd = 5'(rd);
   endtask

   initial begin
      p_rf_en = 0; p_bn_en = 0; p_cok_en = 0; p_ar_en = 0; p_lr_en = 0;
      p_wren = 0; p_bn = 0; p_cok = 0; p_ar = 0; p_lr = 0; p_rd = 0; p_data = '0;
      reset = 1; claim = 0; claim_rd = '0; qn = '0; qm = '0;
      alu_valid = 0; alu_rd = '0; alu_data = '0;
      ld_valid = 0; ld_rd = '0; ld_data = '0;
      #1;
      tick(); tick();
      reset = 0;
      pin_rf(0, 0, 0); pin_bn(0); pin_ar(1); pin_lr(1); pin_cok(1);
      tick();

      // Single ALU result on a reserved register
      qn = 5'd3; qm = 5'd5;
      do_claim(3); pin_cok(1); pin_bn(0); tick();
      idle(); alu(3, 64'h2A); pin_bn(1); pin_ar(1); pin_rf(0, 0, 0); tick();
      idle(); pin_rf(1, 3, 64'h2A); pin_bn(1); tick();
      pin_bn(0); pin_rf(0, 0, 0); tick();

      // Load and ALU on the same cycle: load drains first
      do_claim(5); tick();
      do_claim(6); tick();
      idle(); ld(5, 64'h11); alu(6, 64'h22); pin_ar(1); pin_lr(1); tick();
      idle(); pin_rf(1, 5, 64'h11); tick();
      pin_rf(1, 6, 64'h22); tick();
      pin_rf(0, 0, 0); tick();

      // Backpressure: ALU loses the last slot to a concurrent load
      for (int r = 8; r <= 13; r++) begin
         do_claim(r); tick();
      end
      idle();
      ld(8, 64'h81);  alu(9, 64'h91);  pin_ar(1); tick();
      ld(10, 64'hA1); alu(11, 64'hB1); pin_ar(1); pin_rf(1, 8, 64'h81); tick();
      ld(12, 64'hC1); alu(13, 64'hD1); pin_ar(0); pin_lr(1); pin_rf(1, 9, 64'h91); tick();
      ld_valid = 0; pin_ar(1); pin_rf(1, 10, 64'hA1); tick();
      idle(); pin_rf(1, 11, 64'hB1); tick();
      pin_rf(1, 12, 64'hC1); tick();
      pin_rf(1, 13, 64'hD1); tick();
      pin_rf(0, 0, 0); tick();

      // Zero register: handshakes complete, nothing written or tracked
      qn = 5'd31;
      alu(31, 64'hFF); ld(31, 64'hEE); do_claim(31);
      pin_ar(1); pin_lr(1); pin_cok(1); pin_bn(0); tick();
      idle(); pin_rf(0, 0, 0); pin_bn(0); tick();
      tick();

      // Counter saturation on X7
      qn = 5'd7;
      for (int i = 0; i < 3; i++) begin
         do_claim(7); pin_cok(1); tick();
      end
      do_claim(7); pin_cok(0); pin_bn(1); tick();
      idle(); alu(7, 64'h77); pin_cok(0); tick();
      idle(); pin_rf(1, 7, 64'h77); pin_cok(0); tick();
      pin_cok(1); tick();
      alu(7, 64'h78); tick();
      idle(); do_claim(7); pin_rf(1, 7, 64'h78); pin_cok(1); tick();
      do_claim(7); pin_cok(1); tick();
      do_claim(7); pin_cok(0); tick();
      idle();

      // Reset in the middle of traffic discards queue and reservations
      alu(7, 64'h70); tick();
      alu(7, 64'h71); pin_rf(1, 7, 64'h70); tick();
      reset = 1; alu(7, 64'h72); tick();
      tick();
      reset = 0; idle();
      pin_rf(0, 0, 0); pin_bn(0); pin_ar(1); pin_lr(1); pin_cok(1); tick();
      pin_rf(0, 0, 0); pin_bn(0); tick();
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
